// File: rtl/proc_mc_pkg.sv
// proc_mc_pkg: opcodes, FSM encoding, instruction field positions and immediate sign-extension for proc_mc
package proc_mc_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_XOR  = 6'd4;
    localparam logic [5:0] OP_SHL  = 6'd5;
    localparam logic [5:0] OP_SHR  = 6'd6;
    localparam logic [5:0] OP_ADDI = 6'd7;
    localparam logic [5:0] OP_LD   = 6'd8;
    localparam logic [5:0] OP_ST   = 6'd9;
    localparam logic [5:0] OP_BEQ  = 6'd10;
    localparam logic [5:0] OP_JMP  = 6'd11;
    localparam logic [5:0] OP_HALT = 6'd63;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS_MSB  = 20;
    localparam int RS_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    // Widest supported datapath is 64 bits; callers size-cast down to XLEN.
    function automatic logic [63:0] sext16(input logic [15:0] v);
        return {{48{v[15]}}, v};
    endfunction

endpackage

// File: rtl/proc_mc_regfile.sv
// proc_mc_regfile: NREG x XLEN register file, r0 hardwired to zero
// Ports: clk, rst (async, active-high, clears all registers);
//        we/waddr/wdata synchronous write; raddr_a/raddr_b -> rdata_a/rdata_b asynchronous reads.
module proc_mc_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/proc_mc.sv
// proc_mc: multi-cycle CPU sharing one req/ack memory port between instruction fetch and load/store
// Ports: clk, rst (async, active-high);
//        mem_req/mem_we/mem_addr/mem_wdata registered request, held until mem_ack;
//        mem_rdata/mem_ack read data and one-cycle completion strobe;
//        pc address of the current instruction; halted sticky once HALT retires.
module proc_mc
    import proc_mc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [XLEN-1:0] pc,
    output logic            halted
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int SW = $clog2(XLEN);

    state_t          state, state_n;
    logic [31:0]     ir;
    logic [XLEN-1:0] a_q, b_q, alu_q, alu_y, imm, ra, rb, pc_n, addr_n, wdata_n;
    logic [5:0]      op;
    logic [AW-1:0]   rd, rs;
    logic            ack_v, is_alu, is_mem, req_n, we_n;

    assign op     = ir[OP_MSB:OP_LSB];
    assign rd     = ir[RD_LSB +: AW];
    assign rs     = ir[RS_LSB +: AW];
    assign imm    = XLEN'(sext16(ir[IMM_MSB:IMM_LSB]));
    assign is_alu = op <= OP_ADDI;
    assign is_mem = op == OP_LD || op == OP_ST;
    // An ack outside an outstanding request (e.g. straight after reset) is dropped.
    assign ack_v  = mem_ack & mem_req;

    proc_mc_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (state == S_WB),
        .waddr  (rd),
        .wdata  (alu_q),
        .raddr_a(rd),
        .raddr_b(rs),
        .rdata_a(ra),
        .rdata_b(rb)
    );

    // Branch/jump targets share the ALU adder through the default arm.
    always_comb begin
        case (op)
            OP_ADD:               alu_y = a_q + b_q;
            OP_SUB:               alu_y = a_q - b_q;
            OP_AND:               alu_y = a_q & b_q;
            OP_OR:                alu_y = a_q | b_q;
            OP_XOR:               alu_y = a_q ^ b_q;
            OP_SHL:               alu_y = a_q << b_q[SW-1:0];
            OP_SHR:               alu_y = a_q >> b_q[SW-1:0];
            OP_ADDI, OP_LD, OP_ST: alu_y = b_q + imm;
            default:              alu_y = pc + imm;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            halted    <= state_n == S_HALT;
            if (state == S_FETCH && ack_v) ir <= 32'(mem_rdata);
            if (state == S_DECODE) begin
                a_q <= ra;
                b_q <= rb;
            end
            if (state == S_EXEC) alu_q <= alu_y;
            if (state == S_MEM && ack_v) alu_q <= mem_rdata;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:  state_n = ack_v ? S_DECODE : S_FETCH;
            S_DECODE: state_n = S_EXEC;
            S_EXEC:   state_n = is_mem ? S_MEM : is_alu ? S_WB : op == OP_HALT ? S_HALT : S_FETCH;
            S_MEM:    state_n = !ack_v ? S_MEM : op == OP_LD ? S_WB : S_FETCH;
            S_WB:     state_n = S_FETCH;
            default:  state_n = S_HALT;
        endcase
    end

    // Outputs are registered, so these are the values they take on the next edge;
    // the fetch address follows the updated pc so a new request starts with the right address.
    always_comb begin
        pc_n = pc;
        if (state == S_EXEC && !is_alu && !is_mem && op != OP_HALT)
            pc_n = (op == OP_JMP || (op == OP_BEQ && a_q == b_q)) ? alu_y : pc + 1'b1;
        else if (state == S_WB || (state == S_MEM && ack_v && op == OP_ST))
            pc_n = pc + 1'b1;
        req_n   = state_n == S_FETCH || state_n == S_MEM;
        we_n    = state_n == S_MEM && op == OP_ST;
        addr_n  = state_n == S_FETCH ? pc_n : state == S_EXEC ? alu_y : mem_addr;
        wdata_n = state == S_EXEC ? a_q : mem_wdata;
    end

endmodule

// File: tb/tb_proc_mc.sv
// tb_proc_mc: directed programs against a wait-state memory model for proc_mc
module tb_proc_mc;

    localparam logic [31:0] HALT_W = 32'hFC00_0000;
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ack, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    logic [31:0] pmem [256];
    logic [31:0] dmem [256];
    logic [31:0] flog [32];
    logic [255:0] dvalid;
    logic        clr = 1'b0;
    logic        stale_ack = 1'b0;
    int          wait_n = 0;
    int          cnt = 0;
    int          fcnt = 0;
    int          total = 0;
    int          bad = 0;

    proc_mc #(.XLEN(32), .NREG(32), .RESET_PC(32'd0)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .pc       (pc),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    assign mem_ack   = (mem_req && cnt == wait_n) || stale_ack;
    assign mem_rdata = dvalid[mem_addr[7:0]] ? dmem[mem_addr[7:0]] : pmem[mem_addr[7:0]];

    always @(posedge clk) begin
        cnt <= (mem_req && !mem_ack) ? cnt + 1 : 0;
        if (clr) begin
            dvalid <= '0;
            fcnt   <= 0;
        end else if (mem_req && mem_ack) begin
            if (mem_we) begin
                dmem[mem_addr[7:0]]   <= mem_wdata;
                dvalid[mem_addr[7:0]] <= 1'b1;
            end else begin
                if (fcnt < 32) flog[fcnt[4:0]] <= mem_addr;
                fcnt <= fcnt + 1;
            end
        end
    end

    function automatic logic [31:0] ins(input int op, input int rd, input int rs, input int imm);
        return {op[5:0], rd[4:0], rs[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] rdm(input int a);
        return dvalid[a[7:0]] ? dmem[a[7:0]] : pmem[a[7:0]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic prep(input int w);
        rst    = 1'b1;
        clr    = 1'b1;
        wait_n = w;
        for (int i = 0; i < 256; i++) pmem[i] = HALT_W;
        repeat (2) @(posedge clk);
        clr = 1'b0;
    endtask

    task automatic go();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_halt(input string tag, input int lim);
        int n = 0;
        while (!halted && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        int n;
        logic [31:0] exp_f [10];

        // Reset state and a zero-wait ALU program
        prep(0);
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        pmem[0] = ins(7, 1, 0, 5);
        pmem[1] = ins(7, 2, 0, -3);
        pmem[2] = ins(0, 1, 2, 0);
        pmem[3] = ins(9, 1, 0, 32);
        pmem[32] = JUNK;
        go();
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mem_req && n < 20);
        chk("a_first_req", 32'(mem_req), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        chk("a_pc_after_12", pc, 32'd3);
        run_halt("a_halt", 200);
        chk("a_fetch0", flog[0], 32'd0);
        chk("a_fetch1", flog[1], 32'd1);
        chk("a_fetch2", flog[2], 32'd2);
        chk("a_r1_sum", rdm(32), 32'd2);
        chk("a_halt_req", 32'(mem_req), 32'd0);

        // r0 hardwiring, ST/LD with three wait cycles
        prep(3);
        pmem[0] = ins(7, 0, 0, 7);
        pmem[1] = ins(0, 3, 0, 0);
        pmem[2] = ins(9, 0, 0, 40);
        pmem[3] = ins(9, 3, 0, 41);
        pmem[4] = ins(7, 1, 0, 16'h1234);
        pmem[5] = ins(9, 1, 0, 16);
        pmem[6] = ins(8, 4, 0, 16);
        pmem[7] = ins(9, 4, 0, 42);
        pmem[40] = JUNK;
        pmem[41] = JUNK;
        pmem[42] = JUNK;
        go();
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(mem_req && mem_we && mem_addr == 32'd16) && n < 300);
        chk("b_st_seen", 32'(mem_req && mem_we && mem_addr == 32'd16), 32'd1);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("b_st_req_c%0d", c), 32'(mem_req), 32'd1);
            chk($sformatf("b_st_we_c%0d", c), 32'(mem_we), 32'd1);
            chk($sformatf("b_st_addr_c%0d", c), mem_addr, 32'd16);
            chk($sformatf("b_st_wdata_c%0d", c), mem_wdata, 32'h1234);
            @(posedge clk);
            #1;
        end
        chk("b_st_we_drop", 32'(mem_we), 32'd0);
        run_halt("b_halt", 400);
        chk("b_r0_reads_zero", rdm(40), 32'd0);
        chk("b_r3_stays_zero", rdm(41), 32'd0);
        chk("b_ld_r4", rdm(42), 32'h1234);

        // Branches, jumps through pc wrap, arithmetic wrap and logic ops
        prep(0);
        pmem[0]   = ins(7, 1, 0, 1);
        pmem[1]   = ins(11, 0, 0, -2);
        pmem[255] = ins(11, 0, 0, 4);
        pmem[3]   = ins(7, 2, 2, 1);
        pmem[4]   = ins(12, 0, 0, 0);
        pmem[5]   = ins(10, 2, 1, -2);
        pmem[6]   = ins(9, 2, 0, 50);
        pmem[7]   = ins(7, 5, 0, -1);
        pmem[8]   = ins(7, 5, 5, 1);
        pmem[9]   = ins(9, 5, 0, 51);
        pmem[10]  = ins(7, 6, 0, 31);
        pmem[11]  = ins(7, 7, 0, 1);
        pmem[12]  = ins(5, 7, 6, 0);
        pmem[13]  = ins(7, 7, 7, -1);
        pmem[14]  = ins(7, 8, 7, 1);
        pmem[15]  = ins(9, 8, 0, 52);
        pmem[16]  = ins(1, 8, 7, 0);
        pmem[17]  = ins(9, 8, 0, 53);
        pmem[18]  = ins(7, 9, 0, 16'h0F0F);
        pmem[19]  = ins(7, 10, 0, 16'h00FF);
        pmem[20]  = ins(7, 11, 9, 0);
        pmem[21]  = ins(2, 11, 10, 0);
        pmem[22]  = ins(9, 11, 0, 54);
        pmem[23]  = ins(7, 11, 9, 0);
        pmem[24]  = ins(3, 11, 10, 0);
        pmem[25]  = ins(9, 11, 0, 55);
        pmem[26]  = ins(4, 9, 10, 0);
        pmem[27]  = ins(9, 9, 0, 56);
        pmem[28]  = ins(7, 12, 0, 4);
        pmem[29]  = ins(6, 9, 12, 0);
        pmem[30]  = ins(9, 9, 0, 57);
        for (int i = 50; i < 58; i++) pmem[i] = JUNK;
        go();
        run_halt("c_halt", 2000);
        exp_f = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd3, 32'd4, 32'd5, 32'd3, 32'd4, 32'd5, 32'd6};
        for (int i = 0; i < 10; i++) chk($sformatf("c_fetch%0d", i), flog[i], exp_f[i]);
        chk("c_loop_count", rdm(50), 32'd2);
        chk("c_wrap_zero", rdm(51), 32'd0);
        chk("c_signed_wrap", rdm(52), 32'h8000_0000);
        chk("c_sub", rdm(53), 32'd1);
        chk("c_and", rdm(54), 32'h0000_000F);
        chk("c_or", rdm(55), 32'h0000_0FFF);
        chk("c_xor", rdm(56), 32'h0000_0FF0);
        chk("c_shr", rdm(57), 32'h0000_00FF);

        // Reset during a pending load, stale ack afterwards, then HALT
        prep(2);
        pmem[0] = ins(7, 1, 0, 9);
        pmem[1] = ins(8, 2, 0, 16);
        go();
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(mem_req && !mem_we && mem_addr == 32'd16) && n < 100);
        chk("d_ld_seen", 32'(mem_req && !mem_we && mem_addr == 32'd16), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("d_rst_req", 32'(mem_req), 32'd0);
        chk("d_rst_we", 32'(mem_we), 32'd0);
        chk("d_rst_pc", pc, 32'd0);
        chk("d_rst_halted", 32'(halted), 32'd0);
        clr = 1'b1;
        pmem[0]  = ins(9, 1, 0, 60);
        pmem[1]  = HALT_W;
        pmem[60] = JUNK;
        repeat (2) @(posedge clk);
        clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        stale_ack = 1'b1;
        @(posedge clk);
        #1;
        stale_ack = 1'b0;
        chk("d_stale_ack_req", 32'(mem_req), 32'd1);
        chk("d_stale_ack_addr", mem_addr, 32'd0);
        chk("d_stale_ack_pc", pc, 32'd0);
        run_halt("d_halt", 100);
        chk("d_regs_cleared", rdm(60), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("d_halt_req_c%0d", c), 32'(mem_req), 32'd0);
            chk($sformatf("d_halt_sticky_c%0d", c), 32'(halted), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/proc_mc.md
Name: proc_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle core: one shared memory port with a req/ack handshake, so instruction and data memories may have variable latency.
- Adds configurable data width and register count, hardwired-zero r0, conditional branch, jump and halt.
- Sits between the testbench/SoC memory model and nothing else; it is the top-level CPU.

Parameters:
- XLEN, 32, datapath and address width (>=16)
- NREG, 32, number of registers (power of 2, <=32)
- RESET_PC, 0, pc value after reset

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- mem_req  out  1  memory request; held until ack
- mem_we  out  1  1=store, 0=read; valid with mem_req
- mem_addr  out  XLEN  word address; valid with mem_req
- mem_wdata  out  XLEN  store data; valid with mem_req & mem_we
- mem_rdata  in  XLEN  read data; valid in the ack cycle
- mem_ack  in  1  one-cycle completion strobe
- pc  out  XLEN  address of the current instruction
- halted  out  1  high once HALT has retired; sticky until reset

Behaviour:
- Reset (async): pc=RESET_PC, state=FETCH, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, all registers 0, IR=0. Reset mid-transaction drops mem_req immediately; a later ack is ignored.
- Instruction format (low 32 bits of the fetched word): [31:26] op, [25:21] rd, [20:16] rs, [15:0] imm, sign-extended to XLEN. Register indices use the low log2(NREG) bits.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: rd=rd op rs.
  - 5 SHL, 6 SHR (logical): shift amount = rs[log2(XLEN)-1:0].
  - 7 ADDI: rd=rs+imm.
  - 8 LD: rd=M[rs+imm].
  - 9 ST: M[rs+imm]=rd.
  - 10 BEQ: if rd==rs then pc=pc+imm, else pc+1.
  - 11 JMP: pc=pc+imm.
  - 63 HALT.
  - Any other op is a NOP.
- Arithmetic wraps mod 2^XLEN. Writes to r0 are discarded; r0 always reads 0.
- FSM states:
  - FETCH: mem_req=1, we=0, addr=pc. Go to DECODE in the cycle after ack, with IR latched on ack.
  - DECODE: read rd/rs into A/B latches, then EXEC.
  - EXEC: ALU result latched. LD/ST go to MEM. ALU ops go to WB. BEQ/JMP/NOP update pc and go to FETCH. HALT goes to HALT.
  - MEM: mem_req=1, addr=ALU result, we=(op==ST), wdata=A. On ack: LD goes to WB with rdata latched; ST updates pc=pc+1 and goes to FETCH.
  - WB: write rd, pc=pc+1, then FETCH.
  - HALT: halted=1, mem_req=0. Stays in HALT until reset.
- Handshake:
  - mem_addr/mem_we/mem_wdata are stable while mem_req=1.
  - mem_req deasserts in the cycle after ack. The earliest ack is in the first mem_req cycle (combinational memory allowed).
  - An ack while mem_req=0 is ignored.
- Cycle counts with zero-wait memory:
  - ALU ops: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LD: 5 cycles. ST: 4 cycles.
  - BEQ/JMP/NOP: 3 cycles.
  - Each wait cycle adds 1.
- pc wraps mod 2^XLEN. A branch target uses the pc of the branch itself.
- All outputs are registered except pc, which is a direct register.

Decomposition:
- Package proc_mc_pkg holds:
  - opcode localparams
  - state encoding
  - field positions: OP_MSB/LSB, RD, RS, IMM
  - a sign-extension function
- One sub-module, proc_mc_regfile:
  - parametrised XLEN/NREG
  - 2 asynchronous read ports, 1 synchronous write port
  - r0 hardwired to 0
  - async reset clears all registers
- The ALU stays inline as a case statement.

Test Plan:
- Zero-wait program with r1 = ADDI r0+5 and r2 = ADDI r0-3, then ADD r1,r2 -> r1=2. pc=3 after 12 cycles; fetch addresses 0,1,2 observed.
- ADDI r0,r0,7 then ADD r3,r0 -> r0 reads 0 and r3 stays 0.
- ST r1(=0x1234) to [r0+16], then LD r4,[r0+16], with memory acking after 3 wait cycles -> mem_we=1, addr=16, wdata=0x1234 held stable for 4 cycles; r4=0x1234.
- BEQ r0,r0,-2 at pc=5 -> next fetch addr=3. BEQ with unequal regs at pc=5 -> next fetch addr=6.
- With XLEN=16, ADDI r1 = 0x7FFF+1 -> r1=0x8000, and 0xFFFF+1 -> 0. JMP at pc=0xFFFF with imm=1 -> pc=0.
- Assert rst during a pending LD with ack arriving 1 cycle after reset -> mem_req=0 immediately, pc=RESET_PC, registers 0, and the stale ack does not advance the FSM. HALT -> halted=1 and mem_req=0 thereafter.
